// File: rtl/vend_pkg.sv
// Shared vending definitions: coin codes, coin values and payout FSM states.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_5    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_DONE   = 3'd3,
    ST_JAM    = 3'd4
  } pay_state_e;

  // Face value of a coin code; COIN_NONE is worth nothing.
  function automatic logic [2:0] coin_value(input logic [1:0] code);
    logic [2:0] val;
    case (code)
      COIN_1:  val = 3'd1;
      COIN_2:  val = 3'd2;
      COIN_5:  val = 3'd5;
      default: val = 3'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// Per-denomination coin inventory: three saturating up/down counters.
// inc_code adds one coin, dec_code removes one; both on the same code cancel.
module coin_inventory
  import vend_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int INIT_CNT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       inc_code,
  input  logic [1:0]       dec_code,
  output logic [CNT_W-1:0] inv_1,
  output logic [CNT_W-1:0] inv_2,
  output logic [CNT_W-1:0] inv_5
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_CNT);

  // Counter gi serves coin code gi+1 (COIN_1, COIN_2, COIN_5).
  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    localparam logic [1:0] CODE = 2'(gi + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             inc_hit;
    logic             dec_hit;

    // Next count: saturate at the top on refill, never go below zero.
    always_comb begin
      inc_hit = (inc_code == CODE);
      dec_hit = (dec_code == CODE) && (cnt_q != '0);
      cnt_d   = cnt_q;
      if (inc_hit && !dec_hit) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end else if (dec_hit && !inc_hit) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    // Count register, reloaded with the initial stock on reset.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= CNT_INIT;
      else          cnt_q <= cnt_d;
    end
  end

  assign inv_1 = g_cnt[0].cnt_q;
  assign inv_2 = g_cnt[1].cnt_q;
  assign inv_5 = g_cnt[2].cnt_q;

endmodule

// File: rtl/change_payout_sequencer.sv
// Change payout sequencer: pays an amount coin-by-coin through a hopper,
// choosing 5, 2, 1 greedily from stock, flagging short payouts and jams.
module change_payout_sequencer
  import vend_pkg::*;
#(
  parameter int AMT_W       = 4,
  parameter int CNT_W       = 4,
  parameter int INIT_CNT    = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             change_req,
  input  logic [AMT_W-1:0] change_amt,
  output logic             busy,
  output logic             hop_req,
  output logic [1:0]       hop_denom,
  input  logic             hop_ack,
  input  logic             refill,
  input  logic [1:0]       refill_denom,
  input  logic             jam_clr,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] owed,
  output logic             jam,
  output logic [CNT_W-1:0] inv_1,
  output logic [CNT_W-1:0] inv_2,
  output logic [CNT_W-1:0] inv_5
);

  localparam int               TMO_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [AMT_W-1:0] VAL_1    = AMT_W'(coin_value(COIN_1));
  localparam logic [AMT_W-1:0] VAL_2    = AMT_W'(coin_value(COIN_2));
  localparam logic [AMT_W-1:0] VAL_5    = AMT_W'(coin_value(COIN_5));

  pay_state_e       state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] owed_q, owed_d;
  logic [1:0]       denom_q, denom_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             short_q, short_d;
  logic             jam_q, jam_d;
  logic             done_q, done_d;
  logic [1:0]       pick;
  logic [1:0]       dec_code;
  logic [1:0]       inc_code;

  assign inc_code = refill ? refill_denom : COIN_NONE;

  coin_inventory #(
    .CNT_W    (CNT_W),
    .INIT_CNT (INIT_CNT)
  ) u_inv (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc_code (inc_code),
    .dec_code (dec_code),
    .inv_1    (inv_1),
    .inv_2    (inv_2),
    .inv_5    (inv_5)
  );

  // Greedy choice: largest coin that fits the remainder and is in stock.
  always_comb begin
    pick = COIN_NONE;
    if      ((rem_q >= VAL_5) && (inv_5 != '0)) pick = COIN_5;
    else if ((rem_q >= VAL_2) && (inv_2 != '0)) pick = COIN_2;
    else if ((rem_q >= VAL_1) && (inv_1 != '0)) pick = COIN_1;
  end

  // Payout FSM next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    owed_d   = owed_q;
    denom_d  = denom_q;
    tmo_d    = tmo_q;
    short_d  = short_q;
    jam_d    = jam_q;
    done_d   = 1'b0;
    dec_code = COIN_NONE;
    case (state_q)
      ST_IDLE: begin
        if (change_req) begin
          rem_d   = change_amt;
          short_d = 1'b0;
          owed_d  = '0;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (rem_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (pick != COIN_NONE) begin
          denom_d = pick;
          tmo_d   = '0;
          state_d = ST_ISSUE;
        end else begin
          // Nothing in stock fits: stop here, report what is still owed.
          short_d = 1'b1;
          owed_d  = rem_q;
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (hop_ack) begin
          // The coin fitted when chosen, so this subtraction cannot wrap.
          rem_d    = rem_q - AMT_W'(coin_value(denom_q));
          dec_code = denom_q;
          state_d  = ST_SELECT;
        end else if (tmo_q == TMO_LAST) begin
          jam_d   = 1'b1;
          short_d = 1'b1;
          owed_d  = rem_q;
          done_d  = 1'b1;
          state_d = ST_JAM;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_JAM: begin
        if (jam_clr) begin
          jam_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any payout in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      owed_q  <= '0;
      denom_q <= COIN_NONE;
      tmo_q   <= '0;
      short_q <= 1'b0;
      jam_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      owed_q  <= owed_d;
      denom_q <= denom_d;
      tmo_q   <= tmo_d;
      short_q <= short_d;
      jam_q   <= jam_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign hop_req   = (state_q == ST_ISSUE);
  assign hop_denom = hop_req ? denom_q : COIN_NONE;
  assign done      = done_q;
  assign short     = short_q;
  assign owed      = owed_q;
  assign jam       = jam_q;

endmodule

// File: tb/tb_change_payout_sequencer.sv
// Directed bench for change_payout_sequencer with a coin scoreboard.
module tb_change_payout_sequencer;
  import vend_pkg::*;

  localparam int AMT_W = 4;
  localparam int CNT_W = 4;

  logic             clk          = 1'b0;
  logic             reset_n      = 1'b0;
  logic             change_req   = 1'b0;
  logic [AMT_W-1:0] change_amt   = '0;
  logic             hop_ack      = 1'b0;
  logic             refill       = 1'b0;
  logic [1:0]       refill_denom = 2'b00;
  logic             jam_clr      = 1'b0;
  logic             busy, hop_req, done, short, jam;
  logic [1:0]       hop_denom;
  logic [AMT_W-1:0] owed;
  logic [CNT_W-1:0] inv_1, inv_2, inv_5;

  int         checks   = 0;
  int         passes   = 0;
  int         done_cnt = 0;
  int         paid     = 0;
  int         cur_amt  = 0;
  logic [1:0] exp_q[$];

  change_payout_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .change_req   (change_req),
    .change_amt   (change_amt),
    .busy         (busy),
    .hop_req      (hop_req),
    .hop_denom    (hop_denom),
    .hop_ack      (hop_ack),
    .refill       (refill),
    .refill_denom (refill_denom),
    .jam_clr      (jam_clr),
    .done         (done),
    .short        (short),
    .owed         (owed),
    .jam          (jam),
    .inv_1        (inv_1),
    .inv_2        (inv_2),
    .inv_5        (inv_5)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  function automatic int tb_val(input logic [1:0] c);
    if (c == 2'b01) return 1;
    if (c == 2'b10) return 2;
    if (c == 2'b11) return 5;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int amt);
    change_amt = AMT_W'(amt);
    change_req = 1'b1;
    tick();
    change_req = 1'b0;
    paid       = 0;
    cur_amt    = amt;
  endtask

  task automatic do_refill(input logic [1:0] c);
    refill       = 1'b1;
    refill_denom = c;
    tick();
    refill       = 1'b0;
    refill_denom = 2'b00;
  endtask

  // Wait (bounded) for a coin request and score its denomination.
  task automatic await_coin(output logic got);
    logic [1:0] expd;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (hop_req === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("hop_req_seen", {31'd0, got}, 32'd1);
    if (got) begin
      expd = (exp_q.size() != 0) ? exp_q.pop_front() : 2'b00;
      chk("hop_denom", {30'd0, hop_denom}, {30'd0, expd});
    end
  endtask

  task automatic serve_coin(input logic refill_one);
    logic got;
    await_coin(got);
    if (got) begin
      paid    = paid + tb_val(hop_denom);
      hop_ack = 1'b1;
      if (refill_one) begin
        refill       = 1'b1;
        refill_denom = COIN_1;
      end
      tick();
      hop_ack      = 1'b0;
      refill       = 1'b0;
      refill_denom = 2'b00;
      chk("hop_req_gap", {31'd0, hop_req}, 32'd0);
    end
  endtask

  task automatic wait_done(input logic exp_short, input int exp_owed);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("short", {31'd0, short}, {31'd0, exp_short});
    chk("owed", {28'd0, owed}, exp_owed);
    chk("paid_sum", paid, cur_amt - int'(owed));
    tick();
    chk("done_width", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic got;
    int   d0;

    // 1: reset state, then 8 -> 5,2,1
    tick();
    tick();
    reset_n = 1'b1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hop_req", {31'd0, hop_req}, 32'd0);
    chk("rst_hop_denom", {30'd0, hop_denom}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_short", {31'd0, short}, 32'd0);
    chk("rst_jam", {31'd0, jam}, 32'd0);
    chk("rst_owed", {28'd0, owed}, 32'd0);
    chk("rst_inv1", {28'd0, inv_1}, 32'd4);
    chk("rst_inv2", {28'd0, inv_2}, 32'd4);
    chk("rst_inv5", {28'd0, inv_5}, 32'd4);
    exp_q.push_back(COIN_5); exp_q.push_back(COIN_2); exp_q.push_back(COIN_1);
    req(8);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    serve_coin(1'b0); serve_coin(1'b0); serve_coin(1'b0);
    wait_done(1'b0, 0);
    chk("t1_inv5", {28'd0, inv_5}, 32'd3);
    chk("t1_inv2", {28'd0, inv_2}, 32'd3);
    chk("t1_inv1", {28'd0, inv_1}, 32'd3);

    // 2: zero amount, done two edges after acceptance
    req(0);
    chk("t2_no_early_done", {31'd0, done}, 32'd0);
    chk("t2_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t2_done_at_2", {31'd0, done}, 32'd1);
    chk("t2_no_hop", {31'd0, hop_req}, 32'd0);
    wait_done(1'b0, 0);

    // Drain stock to inv_5=0, inv_2=1, inv_1=0 (7: ignored mid-payout request)
    exp_q.push_back(COIN_5); exp_q.push_back(COIN_5); exp_q.push_back(COIN_5);
    req(15);
    serve_coin(1'b0); serve_coin(1'b0); serve_coin(1'b0);
    wait_done(1'b0, 0);
    exp_q.push_back(COIN_2); exp_q.push_back(COIN_1);
    req(3);
    serve_coin(1'b0);
    change_amt = 4'd9;
    change_req = 1'b1;
    tick();
    change_req = 1'b0;
    serve_coin(1'b0);
    wait_done(1'b0, 0);
    exp_q.push_back(COIN_2); exp_q.push_back(COIN_1);
    req(3);
    serve_coin(1'b0); serve_coin(1'b0);
    wait_done(1'b0, 0);
    exp_q.push_back(COIN_1);
    req(1);
    serve_coin(1'b0);
    wait_done(1'b0, 0);
    chk("t3_pre_inv5", {28'd0, inv_5}, 32'd0);
    chk("t3_pre_inv2", {28'd0, inv_2}, 32'd1);
    chk("t3_pre_inv1", {28'd0, inv_1}, 32'd0);

    // 3: 7 with that stock -> one 2, then short with owed 5
    exp_q.push_back(COIN_2);
    req(7);
    serve_coin(1'b0);
    wait_done(1'b1, 5);

    // 4: hopper jam
    do_refill(COIN_5);
    chk("t4_inv5_refill", {28'd0, inv_5}, 32'd1);
    do_refill(COIN_NONE);
    chk("t4_none_inv5", {28'd0, inv_5}, 32'd1);
    chk("t4_none_inv2", {28'd0, inv_2}, 32'd0);
    chk("t4_none_inv1", {28'd0, inv_1}, 32'd0);
    exp_q.push_back(COIN_5);
    req(5);
    chk("t4_short_cleared", {31'd0, short}, 32'd0);
    await_coin(got);
    for (int i = 0; i < 14; i++) tick();
    chk("t4_no_jam_yet", {31'd0, jam}, 32'd0);
    chk("t4_req_held", {31'd0, hop_req}, 32'd1);
    tick();
    chk("t4_jam", {31'd0, jam}, 32'd1);
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_hop_low", {31'd0, hop_req}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    chk("t4_short", {31'd0, short}, 32'd1);
    chk("t4_owed", {28'd0, owed}, 32'd5);
    chk("t4_paid_sum", paid, cur_amt - int'(owed));
    tick();
    chk("t4_done_width", {31'd0, done}, 32'd0);
    change_amt = 4'd3;
    change_req = 1'b1;
    tick();
    change_req = 1'b0;
    tick();
    chk("t4_ign_busy", {31'd0, busy}, 32'd1);
    chk("t4_ign_jam", {31'd0, jam}, 32'd1);
    chk("t4_ign_hop", {31'd0, hop_req}, 32'd0);
    chk("t4_ign_owed", {28'd0, owed}, 32'd5);
    jam_clr = 1'b1;
    tick();
    jam_clr = 1'b0;
    chk("t4_clr_busy", {31'd0, busy}, 32'd0);
    chk("t4_clr_jam", {31'd0, jam}, 32'd0);
    chk("t4_clr_short", {31'd0, short}, 32'd1);
    chk("t4_clr_owed", {28'd0, owed}, 32'd5);
    chk("t4_inv5_kept", {28'd0, inv_5}, 32'd1);

    // 5: refill and ack of the same coin cancel; saturation
    do_refill(COIN_1);
    do_refill(COIN_1);
    chk("t5_inv1_two", {28'd0, inv_1}, 32'd2);
    exp_q.push_back(COIN_1);
    req(1);
    serve_coin(1'b1);
    chk("t5_inv1_net", {28'd0, inv_1}, 32'd2);
    wait_done(1'b0, 0);
    for (int i = 0; i < 15; i++) do_refill(COIN_2);
    chk("t5_inv2_full", {28'd0, inv_2}, 32'd15);
    do_refill(COIN_2);
    chk("t5_inv2_sat", {28'd0, inv_2}, 32'd15);

    // 6: asynchronous reset during ISSUE
    exp_q.push_back(COIN_2);
    req(2);
    await_coin(got);
    d0 = done_cnt;
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_hop_low", {31'd0, hop_req}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_inv1", {28'd0, inv_1}, 32'd4);
    chk("t6_inv2", {28'd0, inv_2}, 32'd4);
    chk("t6_inv5", {28'd0, inv_5}, 32'd4);
    reset_n = 1'b1;
    tick(); tick(); tick();
    chk("t6_no_done", done_cnt, d0);
    chk("t6_idle", {31'd0, busy}, 32'd0);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
